// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and default widths
// used by every pipeline register in the core.
package pipe_stage_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic logic stage_occupied(input stage_state_e s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of a pipeline stage: payload plus control bundle,
// loaded on enable and cleared asynchronously by the active-low reset.
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. SKID=1 gives a two-entry skid buffer
// with a registered in_ready; SKID=0 is a single register with comb in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    stage_state_e      state;
    stage_state_e      state_nxt;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              skid_load;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

    assign out_valid = stage_occupied(state);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush wins over any transfer on the same edge
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (SKID != 0) begin
            case (state)
                EMPTY: if (in_xfer) state_nxt = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_nxt = FULL;
                    end else if (!in_xfer && out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL:    if (out_xfer) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end else begin
            if (in_xfer) begin
                state_nxt = ONE;
            end else if (out_xfer) begin
                state_nxt = EMPTY;
            end
        end
    end

    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            if (SKID != 0) begin
                case (state)
                    EMPTY: main_load = in_xfer;
                    ONE: begin
                        main_load = in_xfer & out_xfer;
                        skid_load = in_xfer & ~out_xfer;
                    end
                    FULL: begin
                        main_load      = out_xfer;
                        main_from_skid = out_xfer;
                    end
                    default: main_load = 1'b0;
                endcase
            end else begin
                main_load = in_xfer;
            end
        end
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .q_data (main_data),
        .q_ctrl (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Registered so in_ready never sees out_ready combinationally
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_nxt != FULL);
                end
            end

            assign in_ready = in_ready_q;

            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .q_data (skid_data),
                .q_ctrl (skid_ctrl)
            );
        end else begin : g_noskid
            assign in_ready  = out_ready | ~out_valid;
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg with SKID=1 and SKID=0
// instances driven side by side from one shared clock/reset/flush.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;

    logic          s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [DW-1:0] s1_in_data, s1_out_data;
    logic [CW-1:0] s1_in_ctrl, s1_out_ctrl;

    logic          s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [DW-1:0] s0_in_data, s0_out_data;
    logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;

    int checks = 0;
    int errors = 0;

    logic [39:0] q1[$];
    logic [39:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_in_data),
        .in_ctrl   (s1_in_ctrl),
        .flush     (flush),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_data  (s1_out_data),
        .out_ctrl  (s1_out_ctrl)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_noskid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (s0_in_data),
        .in_ctrl   (s0_in_ctrl),
        .flush     (flush),
        .out_valid (s0_out_valid),
        .out_ready (s0_out_ready),
        .out_data  (s0_out_data),
        .out_ctrl  (s0_out_ctrl)
    );

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return d[7:0] ^ 8'hC3;
    endfunction

    task automatic apply_stimulus1(input logic v, input logic [31:0] d, input logic r);
        s1_in_valid  = v;
        s1_in_data   = d;
        s1_in_ctrl   = ctrl_of(d);
        s1_out_ready = r;
    endtask

    task automatic apply_stimulus0(input logic v, input logic [31:0] d, input logic r);
        s0_in_valid  = v;
        s0_in_data   = d;
        s0_in_ctrl   = ctrl_of(d);
        s0_out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic exp_rdy1, exp_rdy0, pop1, pop0, push1, push0;

        rst   = 1'b0;
        flush = 1'b0;
        apply_stimulus1(1'b0, 32'h0, 1'b0);
        apply_stimulus0(1'b0, 32'h0, 1'b0);

        #12;
        check_output("rst_s1_out_valid", 40'(s1_out_valid), 40'd0);
        check_output("rst_s1_out_ctrl",  40'(s1_out_ctrl),  40'd0);
        check_output("rst_s1_out_data",  40'(s1_out_data),  40'd0);
        check_output("rst_s1_in_ready",  40'(s1_in_ready),  40'd0);
        check_output("rst_s0_out_valid", 40'(s0_out_valid), 40'd0);
        rst = 1'b1;
        tick();
        check_output("post_rst_in_ready", 40'(s1_in_ready), 40'd1);

        $display("[TB] streaming");
        apply_stimulus1(1'b1, 32'h10, 1'b1);
        tick();
        check_output("stream0_valid", 40'(s1_out_valid), 40'd1);
        check_output("stream0_data",  40'(s1_out_data),  40'h10);
        check_output("stream0_ctrl",  40'(s1_out_ctrl),  40'hD3);
        check_output("stream0_ready", 40'(s1_in_ready),  40'd1);
        apply_stimulus1(1'b1, 32'h11, 1'b1);
        tick();
        check_output("stream1_data",  40'(s1_out_data),  40'h11);
        check_output("stream1_ready", 40'(s1_in_ready),  40'd1);
        apply_stimulus1(1'b1, 32'h12, 1'b1);
        tick();
        check_output("stream2_data",  40'(s1_out_data),  40'h12);
        check_output("stream2_ready", 40'(s1_in_ready),  40'd1);
        apply_stimulus1(1'b0, 32'h0, 1'b1);
        tick();
        check_output("stream_drain_valid", 40'(s1_out_valid), 40'd0);
        check_output("stream_drain_ctrl",  40'(s1_out_ctrl),  40'd0);

        $display("[TB] stall fill");
        apply_stimulus1(1'b1, 32'hA1, 1'b0);
        tick();
        check_output("fill1_data",  40'(s1_out_data), 40'hA1);
        check_output("fill1_ready", 40'(s1_in_ready), 40'd1);
        apply_stimulus1(1'b1, 32'hA2, 1'b0);
        tick();
        check_output("fill2_ready", 40'(s1_in_ready), 40'd0);
        check_output("fill2_data",  40'(s1_out_data), 40'hA1);
        apply_stimulus1(1'b0, 32'h0, 1'b0);
        tick();
        check_output("stall_hold_data", 40'(s1_out_data), 40'hA1);
        check_output("stall_hold_ctrl", 40'(s1_out_ctrl), 40'h62);
        apply_stimulus1(1'b0, 32'h0, 1'b1);
        tick();
        check_output("drain_a2_data",  40'(s1_out_data),  40'hA2);
        check_output("drain_a2_valid", 40'(s1_out_valid), 40'd1);
        check_output("drain_a2_ready", 40'(s1_in_ready),  40'd1);
        tick();
        check_output("drain_empty", 40'(s1_out_valid), 40'd0);

        $display("[TB] flush");
        apply_stimulus1(1'b1, 32'hB1, 1'b0);
        tick();
        apply_stimulus1(1'b1, 32'hB2, 1'b0);
        tick();
        check_output("flush_full_ready", 40'(s1_in_ready), 40'd0);
        apply_stimulus1(1'b1, 32'hB3, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_valid", 40'(s1_out_valid), 40'd0);
        check_output("flush_ctrl",  40'(s1_out_ctrl),  40'd0);
        check_output("flush_ready", 40'(s1_in_ready),  40'd1);
        apply_stimulus1(1'b0, 32'h0, 1'b1);
        tick();
        check_output("flush_no_b3", 40'(s1_out_valid), 40'd0);
        apply_stimulus1(1'b1, 32'hB4, 1'b1);
        tick();
        check_output("one_b4_data", 40'(s1_out_data), 40'hB4);
        apply_stimulus1(1'b1, 32'hB5, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_one_valid", 40'(s1_out_valid), 40'd0);
        apply_stimulus1(1'b0, 32'h0, 1'b1);
        tick();
        check_output("flush_no_b5", 40'(s1_out_valid), 40'd0);

        $display("[TB] reset mid-operation");
        apply_stimulus1(1'b1, 32'hD1, 1'b0);
        tick();
        apply_stimulus1(1'b1, 32'hD2, 1'b0);
        tick();
        check_output("pre_rst_full", 40'(s1_in_ready), 40'd0);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_rst_valid", 40'(s1_out_valid), 40'd0);
        check_output("async_rst_ctrl",  40'(s1_out_ctrl),  40'd0);
        check_output("async_rst_ready", 40'(s1_in_ready),  40'd0);
        rst = 1'b1;
        apply_stimulus1(1'b1, 32'hE1, 1'b1);
        tick();
        check_output("rel_valid", 40'(s1_out_valid), 40'd0);
        check_output("rel_ready", 40'(s1_in_ready),  40'd1);
        tick();
        check_output("rel_e1_valid", 40'(s1_out_valid), 40'd1);
        check_output("rel_e1_data",  40'(s1_out_data),  40'hE1);
        apply_stimulus1(1'b0, 32'h0, 1'b1);
        tick();
        check_output("rel_no_replay", 40'(s1_out_valid), 40'd0);

        $display("[TB] single register");
        apply_stimulus0(1'b1, 32'hC4, 1'b0);
        tick();
        check_output("s0_c4_valid", 40'(s0_out_valid), 40'd1);
        check_output("s0_c4_data",  40'(s0_out_data),  40'hC4);
        apply_stimulus0(1'b1, 32'hC5, 1'b0);
        #1;
        check_output("s0_stall_ready", 40'(s0_in_ready), 40'd0);
        s0_out_ready = 1'b1;
        #1;
        check_output("s0_go_ready", 40'(s0_in_ready), 40'd1);
        tick();
        check_output("s0_c5_data",  40'(s0_out_data),  40'hC5);
        check_output("s0_c5_ctrl",  40'(s0_out_ctrl),  40'h06);
        apply_stimulus0(1'b0, 32'h0, 1'b1);
        tick();
        check_output("s0_empty_valid", 40'(s0_out_valid), 40'd0);
        check_output("s0_empty_ctrl",  40'(s0_out_ctrl),  40'd0);

        $display("[TB] random scoreboard");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush        = ($urandom_range(0, 9) == 0);
            s1_in_valid  = ($urandom_range(0, 99) < 70);
            s1_out_ready = ($urandom_range(0, 99) < 60);
            s1_in_data   = $urandom;
            s1_in_ctrl   = 8'($urandom);
            s0_in_valid  = ($urandom_range(0, 99) < 70);
            s0_out_ready = ($urandom_range(0, 99) < 60);
            s0_in_data   = $urandom;
            s0_in_ctrl   = 8'($urandom);
            #1;
            exp_rdy1 = (q1.size() < 2);
            exp_rdy0 = s0_out_ready | (q0.size() == 0);
            check_output("rnd_s1_ready", 40'(s1_in_ready),  40'(exp_rdy1));
            check_output("rnd_s1_valid", 40'(s1_out_valid), 40'(q1.size() != 0));
            check_output("rnd_s0_ready", 40'(s0_in_ready),  40'(exp_rdy0));
            check_output("rnd_s0_valid", 40'(s0_out_valid), 40'(q0.size() != 0));
            if (q1.size() != 0) check_output("rnd_s1_entry", {s1_out_ctrl, s1_out_data}, q1[0]);
            else                check_output("rnd_s1_ctrl0", 40'(s1_out_ctrl), 40'd0);
            if (q0.size() != 0) check_output("rnd_s0_entry", {s0_out_ctrl, s0_out_data}, q0[0]);
            else                check_output("rnd_s0_ctrl0", 40'(s0_out_ctrl), 40'd0);
            pop1  = (q1.size() != 0) && s1_out_ready;
            pop0  = (q0.size() != 0) && s0_out_ready;
            push1 = s1_in_valid && exp_rdy1;
            push0 = s0_in_valid && exp_rdy0;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (pop0) void'(q0.pop_front());
                if (push1) q1.push_back({s1_in_ctrl, s1_in_data});
                if (push0) q0.push_back({s0_in_ctrl, s0_in_data});
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
